// File: rtl/rv4028_bus_sequencer.sv
// RV4028 external 16-bit bus sequencer: arbitrates fetch/data ports and runs
// one or two T1/T2/T3 bus cycles per word with registered DDR phase-pair strobes.
module rv4028_bus_sequencer #(
    parameter int unsigned MIN_WAIT = 0,
    parameter int unsigned IO_WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_io,
    input  logic [3:0]  d_mask,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] addr,
    output logic        rd_n,
    output logic [1:0]  wr_buf,
    output logic [1:0]  mreq_buf,
    output logic        iorq_n,
    output logic [1:0]  msk_n,
    input  logic        wait_n,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe
);

    typedef enum logic [2:0] {IDLE, T1, T2, T3, DONE} state_t;

    localparam logic [7:0] WAIT_MEM = 8'(MIN_WAIT);
    localparam logic [7:0] WAIT_IO  = 8'(MIN_WAIT + IO_WAIT);

    state_t      state;
    logic        last_data;
    logic        gnt_data;
    logic        half;
    logic [31:2] lat_addr;
    logic        lat_we;
    logic        lat_io;
    logic [3:0]  lat_mask;
    logic [31:0] lat_wdata;
    logic [7:0]  wait_cnt;

    logic        pick_data;
    logic [31:2] cur_addr;
    logic        cur_we;
    logic        cur_io;
    logic [3:0]  cur_mask;
    logic [31:0] cur_wdata;
    logic        th;
    logic        go_t1;
    logic [1:0]  t1_msk_n;
    logic [15:0] t1_dout;
    logic [15:0] cap;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

    // In IDLE the next transaction comes straight from the winning port so T1
    // outputs can be registered on the granting edge; afterwards from latches.
    always_comb begin
        pick_data = d_req && (!i_req || !last_data);
        cur_addr  = lat_addr;
        cur_we    = lat_we;
        cur_io    = lat_io;
        cur_mask  = lat_mask;
        cur_wdata = lat_wdata;
        if (state == IDLE) begin
            cur_addr  = pick_data ? d_addr[31:2] : i_addr[31:2];
            cur_we    = pick_data & d_we;
            cur_io    = pick_data & d_io;
            cur_mask  = pick_data ? d_mask : 4'hF;
            cur_wdata = d_wdata;
        end
        th       = (state == IDLE) ? (cur_mask[1:0] == 2'b00) : 1'b1;
        t1_msk_n = th ? ~cur_mask[3:2] : ~cur_mask[1:0];
        t1_dout  = cur_we ? (th ? cur_wdata[31:16] : cur_wdata[15:0]) : '0;
        go_t1    = ((state == IDLE) && (i_req || d_req) && (cur_mask != 4'h0)) ||
                   ((state == T3) && !half && (lat_mask[3:2] != 2'b00));
        cap      = data_in & (half ? {{8{lat_mask[3]}}, {8{lat_mask[2]}}}
                                   : {{8{lat_mask[1]}}, {8{lat_mask[0]}}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_data <= 1'b1;
            gnt_data  <= 1'b0;
            half      <= 1'b0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_io    <= 1'b0;
            lat_mask  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            addr      <= '0;
            rd_n      <= 1'b1;
            iorq_n    <= 1'b1;
            mreq_buf  <= 2'b11;
            wr_buf    <= 2'b11;
            msk_n     <= 2'b11;
            data_out  <= '0;
            data_oe   <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        gnt_data  <= pick_data;
                        last_data <= pick_data;
                        lat_addr  <= cur_addr;
                        lat_we    <= cur_we;
                        lat_io    <= cur_io;
                        lat_mask  <= cur_mask;
                        lat_wdata <= cur_wdata;
                        if (pick_data) d_rdata <= '0;
                        else           i_rdata <= '0;
                        if (cur_mask == 4'h0) begin
                            state <= DONE;
                            d_ack <= 1'b1;
                        end
                    end
                end
                T1: begin
                    state    <= T2;
                    mreq_buf <= lat_io ? 2'b11 : 2'b00;
                    wr_buf   <= lat_we ? 2'b00 : 2'b11;
                    wait_cnt <= lat_io ? WAIT_IO : WAIT_MEM;
                end
                T2: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end else if (wait_n) begin
                        if (!lat_we) begin
                            if (gnt_data) begin
                                if (half) d_rdata[31:16] <= cap;
                                else      d_rdata[15:0]  <= cap;
                            end else begin
                                if (half) i_rdata[31:16] <= cap;
                                else      i_rdata[15:0]  <= cap;
                            end
                        end
                        state    <= T3;
                        mreq_buf <= lat_io ? 2'b11 : 2'b10;
                        wr_buf   <= lat_we ? 2'b10 : 2'b11;
                    end
                end
                T3: begin
                    if (!go_t1) begin
                        state    <= DONE;
                        addr     <= '0;
                        rd_n     <= 1'b1;
                        iorq_n   <= 1'b1;
                        mreq_buf <= 2'b11;
                        wr_buf   <= 2'b11;
                        msk_n    <= 2'b11;
                        data_out <= '0;
                        data_oe  <= 1'b0;
                        if (gnt_data) d_ack <= 1'b1;
                        else          i_ack <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (go_t1) begin
                state    <= T1;
                half     <= th;
                addr     <= {cur_addr, th, 1'b0};
                msk_n    <= t1_msk_n;
                rd_n     <= cur_we;
                iorq_n   <= ~cur_io;
                mreq_buf <= cur_io ? 2'b11 : 2'b01;
                wr_buf   <= 2'b11;
                data_out <= t1_dout;
                data_oe  <= cur_we;
            end
        end
    end

endmodule

// File: tb/tb_rv4028_bus_sequencer.sv
// Self-checking bench for rv4028_bus_sequencer: per-cycle bus trace checks plus
// an ack scoreboard (port, data, cycle) filled as requests are issued.
module tb_rv4028_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req, d_we, d_io;
    logic [3:0]  d_mask;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_ack;
    logic [31:0] addr;
    logic        rd_n, iorq_n, wait_n, data_oe;
    logic [1:0]  wr_buf, mreq_buf, msk_n;
    logic [15:0] data_in, data_out;

    rv4028_bus_sequencer #(.MIN_WAIT(0), .IO_WAIT(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_io(d_io), .d_mask(d_mask),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .addr(addr), .rd_n(rd_n), .wr_buf(wr_buf), .mreq_buf(mreq_buf),
        .iorq_n(iorq_n), .msk_n(msk_n), .wait_n(wait_n), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int w_lo = 1;
    int w_hi = 0;
    logic in_win;

    function automatic logic [15:0] mem(input logic [31:0] a);
        if (a == 32'h100) return 16'h1234;
        else if (a == 32'h102) return 16'h5678;
        else return a[15:0] ^ 16'h5A3C;
    endfunction

    // Bus slave: data depends on address; corrupted while wait_n is held low.
    always_comb begin
        in_win  = (cyc >= w_lo) && (cyc <= w_hi);
        wait_n  = !in_win;
        data_in = mem(addr) ^ (in_win ? 16'hFFFF : 16'h0000);
    end

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] tr_addr [0:1023];
    logic [1:0]  tr_mreq [0:1023];
    logic [1:0]  tr_wr   [0:1023];
    logic [1:0]  tr_msk  [0:1023];
    logic [15:0] tr_dout [0:1023];
    logic        tr_rd   [0:1023];
    logic        tr_iorq [0:1023];
    logic        tr_oe   [0:1023];
    logic        tr_iack [0:1023];
    logic        tr_dack [0:1023];

    always @(negedge clk) begin
        exp_t e;
        tr_addr[cyc & 1023] = addr;
        tr_mreq[cyc & 1023] = mreq_buf;
        tr_wr[cyc & 1023]   = wr_buf;
        tr_msk[cyc & 1023]  = msk_n;
        tr_dout[cyc & 1023] = data_out;
        tr_rd[cyc & 1023]   = rd_n;
        tr_iorq[cyc & 1023] = iorq_n;
        tr_oe[cyc & 1023]   = data_oe;
        tr_iack[cyc & 1023] = i_ack;
        tr_dack[cyc & 1023] = d_ack;
        if (i_ack || d_ack) begin
            checks++;
            if (i_ack && d_ack) begin
                errors++;
                $display("FAIL ack_overlap: both acks high at cycle %0d, required one", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: i_ack=%b d_ack=%b at cycle %0d, required none", i_ack, d_ack, cyc);
            end else begin
                e = exp_q.pop_front();
                if (d_ack !== e.port || (d_ack ? d_rdata : i_rdata) !== e.data || cyc != e.cyc)
                begin
                    errors++;
                    $display("FAIL scoreboard: got port=%0d data=%h cycle=%0d, required port=%0d data=%h cycle=%0d",
                             d_ack, (d_ack ? d_rdata : i_rdata), cyc, e.port, e.data, e.cyc);
                end
            end
        end
    end

    task automatic drive_fetch(input logic [31:0] a, input logic [31:0] exp_d, input int lat,
                               output int c0, output bit got);
        c0 = cyc;
        got = 1'b0;
        i_addr = a;
        i_req = 1'b1;
        exp_q.push_back('{1'b0, exp_d, c0 + lat});
        for (int k = 0; k < lat + 20; k++) begin
            @(negedge clk);
            if (i_ack) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic drive_data(input logic we, input logic io, input logic [3:0] m,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_d, input int lat,
                              output int c0, output bit got);
        c0 = cyc;
        got = 1'b0;
        d_we = we; d_io = io; d_mask = m; d_addr = a; d_wdata = wd;
        d_req = 1'b1;
        exp_q.push_back('{1'b1, exp_d, c0 + lat});
        for (int k = 0; k < lat + 20; k++) begin
            @(negedge clk);
            if (d_ack) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_n, iorq_n, mreq_buf, wr_buf, msk_n, data_oe, i_ack, d_ack} !== 11'b1_1_11_11_11_0_0_0) begin
            errors++;
            $display("FAIL reset_strobes: got %b, required 11111111000",
                     {rd_n, iorq_n, mreq_buf, wr_buf, msk_n, data_oe, i_ack, d_ack});
        end
        checks++;
        if ({addr, data_out} !== 48'h0) begin
            errors++;
            $display("FAIL reset_addr_data: got addr=%h data_out=%h, required 0", addr, data_out);
        end
        checks++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h %h, required 0", i_rdata, d_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_n, mreq_buf, data_oe, i_ack, d_ack} !== 6'b1_11_0_0_0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, required 111000", {rd_n, mreq_buf, data_oe, i_ack, d_ack});
        end
    endtask

    task automatic test_fetch();
        int c0; bit got;
        logic [31:0] ea; logic [1:0] em;
        @(posedge clk); #1;
        drive_fetch(32'h100, 32'h5678_1234, 7, c0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL fetch_timeout: got no i_ack, required one"); end
        for (int k = 1; k <= 6; k++) begin
            ea = (k <= 3) ? 32'h100 : 32'h102;
            em = ((k - 1) % 3 == 0) ? 2'b01 : (((k - 1) % 3 == 1) ? 2'b00 : 2'b10);
            checks++;
            if ({tr_addr[(c0 + k) & 1023], tr_mreq[(c0 + k) & 1023], tr_rd[(c0 + k) & 1023], tr_msk[(c0 + k) & 1023]}
                !== {ea, em, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL fetch_cycle%0d: got addr=%h mreq=%b rd_n=%b msk_n=%b, required addr=%h mreq=%b rd_n=0 msk_n=00",
                         k, tr_addr[(c0 + k) & 1023], tr_mreq[(c0 + k) & 1023], tr_rd[(c0 + k) & 1023],
                         tr_msk[(c0 + k) & 1023], ea, em);
            end
        end
        checks++;
        if ({tr_mreq[(c0 + 7) & 1023], tr_rd[(c0 + 7) & 1023], tr_iack[(c0 + 7) & 1023], tr_iack[(c0 + 8) & 1023]}
            !== 5'b11_1_1_0) begin
            errors++;
            $display("FAIL fetch_done: got mreq=%b rd_n=%b ack7=%b ack8=%b, required 11 1 1 0",
                     tr_mreq[(c0 + 7) & 1023], tr_rd[(c0 + 7) & 1023], tr_iack[(c0 + 7) & 1023], tr_iack[(c0 + 8) & 1023]);
        end
    endtask

    task automatic test_write();
        int c0; bit got;
        logic [1:0] ew;
        @(posedge clk); #1;
        drive_data(1'b1, 1'b0, 4'b1100, 32'h2000, 32'hAABB_CCDD, 32'h0, 4, c0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL write_timeout: got no d_ack, required one"); end
        for (int k = 1; k <= 3; k++) begin
            ew = (k == 1) ? 2'b11 : ((k == 2) ? 2'b00 : 2'b10);
            checks++;
            if ({tr_addr[(c0 + k) & 1023], tr_msk[(c0 + k) & 1023], tr_dout[(c0 + k) & 1023],
                 tr_oe[(c0 + k) & 1023], tr_wr[(c0 + k) & 1023], tr_rd[(c0 + k) & 1023]}
                !== {32'h2002, 2'b00, 16'hAABB, 1'b1, ew, 1'b1}) begin
                errors++;
                $display("FAIL write_cycle%0d: got addr=%h msk_n=%b dout=%h oe=%b wr=%b rd_n=%b, required 2002 00 aabb 1 %b 1",
                         k, tr_addr[(c0 + k) & 1023], tr_msk[(c0 + k) & 1023], tr_dout[(c0 + k) & 1023],
                         tr_oe[(c0 + k) & 1023], tr_wr[(c0 + k) & 1023], tr_rd[(c0 + k) & 1023], ew);
            end
        end
        checks++;
        if ({tr_oe[(c0 + 4) & 1023], tr_wr[(c0 + 4) & 1023], tr_addr[(c0 + 4) & 1023]} !== {1'b0, 2'b11, 32'h0}) begin
            errors++;
            $display("FAIL write_done: got oe=%b wr=%b addr=%h, required 0 11 0",
                     tr_oe[(c0 + 4) & 1023], tr_wr[(c0 + 4) & 1023], tr_addr[(c0 + 4) & 1023]);
        end
    endtask

    task automatic test_wait_states();
        int c0; bit got;
        logic [1:0] em;
        @(posedge clk); #1;
        w_lo = cyc + 2;
        w_hi = cyc + 4;
        drive_data(1'b0, 1'b0, 4'hF, 32'h300, 32'h0, {mem(32'h302), mem(32'h300)}, 10, c0, got);
        w_lo = 1; w_hi = 0;
        checks++;
        if (!got) begin errors++; $display("FAIL wait_timeout: got no d_ack, required one"); end
        for (int k = 2; k <= 7; k++) begin
            em = (k <= 5) ? 2'b00 : ((k == 6) ? 2'b10 : 2'b01);
            checks++;
            if (tr_mreq[(c0 + k) & 1023] !== em) begin
                errors++;
                $display("FAIL wait_mreq%0d: got %b, required %b", k, tr_mreq[(c0 + k) & 1023], em);
            end
        end
    endtask

    task automatic test_io_read();
        int c0; bit got;
        logic [31:0] ea;
        @(posedge clk); #1;
        drive_data(1'b0, 1'b1, 4'hF, 32'h40, 32'h0, {mem(32'h42), mem(32'h40)}, 9, c0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL io_timeout: got no d_ack, required one"); end
        for (int k = 1; k <= 8; k++) begin
            ea = (k <= 4) ? 32'h40 : 32'h42;
            checks++;
            if ({tr_iorq[(c0 + k) & 1023], tr_mreq[(c0 + k) & 1023], tr_rd[(c0 + k) & 1023], tr_addr[(c0 + k) & 1023]}
                !== {1'b0, 2'b11, 1'b0, ea}) begin
                errors++;
                $display("FAIL io_cycle%0d: got iorq_n=%b mreq=%b rd_n=%b addr=%h, required 0 11 0 %h",
                         k, tr_iorq[(c0 + k) & 1023], tr_mreq[(c0 + k) & 1023], tr_rd[(c0 + k) & 1023],
                         tr_addr[(c0 + k) & 1023], ea);
            end
        end
        checks++;
        if (tr_iorq[(c0 + 9) & 1023] !== 1'b1) begin
            errors++;
            $display("FAIL io_done: got iorq_n=%b, required 1", tr_iorq[(c0 + 9) & 1023]);
        end
    endtask

    task automatic test_zero_mask();
        int c0; bit got;
        @(posedge clk); #1;
        drive_data(1'b1, 1'b0, 4'h0, 32'h900, 32'hDEAD_BEEF, 32'h0, 1, c0, got);
        checks++;
        if (!got || {tr_rd[(c0 + 1) & 1023], tr_mreq[(c0 + 1) & 1023], tr_wr[(c0 + 1) & 1023], tr_oe[(c0 + 1) & 1023]}
            !== 6'b1_11_11_0) begin
            errors++;
            $display("FAIL zero_mask: got ack=%b strobes=%b, required ack=1 strobes=111110", got,
                     {tr_rd[(c0 + 1) & 1023], tr_mreq[(c0 + 1) & 1023], tr_wr[(c0 + 1) & 1023], tr_oe[(c0 + 1) & 1023]});
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        c0 = cyc;
        i_addr = 32'h600; i_req = 1'b1;
        d_we = 1'b0; d_io = 1'b0; d_mask = 4'b0011; d_addr = 32'h500; d_req = 1'b1;
        exp_q.push_back('{1'b0, {mem(32'h602), mem(32'h600)}, c0 + 7});
        exp_q.push_back('{1'b1, {16'h0, mem(32'h500)}, c0 + 12});
        exp_q.push_back('{1'b0, {mem(32'h602), mem(32'h600)}, c0 + 20});
        n = 0;
        for (int k = 0; k < 60 && n < 3; k++) begin
            @(negedge clk);
            if (i_ack || d_ack) n++;
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d acks, required 3", n); end
        checks++;
        if ({tr_rd[(c0 + 8) & 1023], tr_mreq[(c0 + 8) & 1023], tr_rd[(c0 + 13) & 1023], tr_mreq[(c0 + 13) & 1023]}
            !== 6'b1_11_1_11) begin
            errors++;
            $display("FAIL b2b_gap: got %b, required 111111",
                     {tr_rd[(c0 + 8) & 1023], tr_mreq[(c0 + 8) & 1023], tr_rd[(c0 + 13) & 1023], tr_mreq[(c0 + 13) & 1023]});
        end
        checks++;
        if ({tr_addr[(c0 + 9) & 1023], tr_msk[(c0 + 9) & 1023], tr_addr[(c0 + 14) & 1023]}
            !== {32'h500, 2'b00, 32'h600}) begin
            errors++;
            $display("FAIL b2b_grant: got addr9=%h msk9=%b addr14=%h, required 500 00 600",
                     tr_addr[(c0 + 9) & 1023], tr_msk[(c0 + 9) & 1023], tr_addr[(c0 + 14) & 1023]);
        end
    endtask

    task automatic test_reset_abort();
        int c0, c1; bit got;
        int acks;
        @(posedge clk); #1;
        c0 = cyc;
        d_we = 1'b1; d_io = 1'b0; d_mask = 4'hF; d_addr = 32'h700; d_wdata = 32'h1122_3344; d_req = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_n, iorq_n, mreq_buf, wr_buf, msk_n, data_oe, d_ack} !== 10'b1_1_11_11_11_0_0) begin
            errors++;
            $display("FAIL abort_strobes: got %b, required 1111111100",
                     {rd_n, iorq_n, mreq_buf, wr_buf, msk_n, data_oe, d_ack});
        end
        checks++;
        if ({tr_wr[(c0 + 4) & 1023], tr_wr[(c0 + 5) & 1023], tr_addr[(c0 + 5) & 1023]} !== {2'b11, 2'b00, 32'h702}) begin
            errors++;
            $display("FAIL abort_second_t2: got wr4=%b wr5=%b addr=%h, required 11 00 702",
                     tr_wr[(c0 + 4) & 1023], tr_wr[(c0 + 5) & 1023], tr_addr[(c0 + 5) & 1023]);
        end
        repeat (6) @(negedge clk);
        acks = 0;
        for (int k = 0; k <= 12; k++) acks += int'(tr_dack[(c0 + k) & 1023]);
        checks++;
        if (acks != 0) begin errors++; $display("FAIL abort_no_ack: got %0d d_ack, required 0", acks); end
        @(posedge clk); #1;
        drive_data(1'b1, 1'b0, 4'b0011, 32'h800, 32'h9988_7766, 32'h0, 4, c1, got);
        checks++;
        if (!got || {tr_addr[(c1 + 1) & 1023], tr_dout[(c1 + 1) & 1023], tr_msk[(c1 + 1) & 1023]}
            !== {32'h800, 16'h7766, 2'b00}) begin
            errors++;
            $display("FAIL abort_recover: got ack=%b addr=%h dout=%h msk_n=%b, required 1 800 7766 00",
                     got, tr_addr[(c1 + 1) & 1023], tr_dout[(c1 + 1) & 1023], tr_msk[(c1 + 1) & 1023]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_io = 1'b0; d_mask = '0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_fetch();
        test_write();
        test_wait_states();
        test_io_read();
        test_zero_mask();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
